// File: rtl/traffic_pkg.sv
// Shared types and default timing for the two-road phase scheduler.
package traffic_pkg;

  localparam int TIMER_W       = 7;
  localparam int T_GREEN_DEF   = 25;
  localparam int T_YELLOW_DEF  = 3;
  localparam int T_ALLRED_DEF  = 2;
  localparam int T_PED_CUT_DEF = 5;

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    ALLRED_1 = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    ALLRED_2 = 3'd5
  } phase_e;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  // Fixed ring order of the phases.
  function automatic phase_e next_phase(input phase_e p);
    case (p)
      A_GREEN:  return A_YELLOW;
      A_YELLOW: return ALLRED_1;
      ALLRED_1: return B_GREEN;
      B_GREEN:  return B_YELLOW;
      B_YELLOW: return ALLRED_2;
      default:  return A_GREEN;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable 7-bit down counter with hold; load wins over decrement.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int RST_VAL = T_GREEN_DEF
) (
  input  logic               clk_i,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic [TIMER_W-1:0] cnt_o
);

  logic [TIMER_W-1:0] cnt_d, cnt_q;

  // Next count: load, decrement or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - 7'd1;
    end
  end

  // Count register, reset to the first phase's duration.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      cnt_q <= 7'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/phase_scheduler.sv
// Two-road traffic phase scheduler with auto/manual modes.
// Optional pedestrian-request green shortening is built when PED_REQ_EN is defined.
module phase_scheduler
  import traffic_pkg::*;
#(
  parameter int T_GREEN   = T_GREEN_DEF,
  parameter int T_YELLOW  = T_YELLOW_DEF,
  parameter int T_ALLRED  = T_ALLRED_DEF,
  parameter int T_PED_CUT = T_PED_CUT_DEF
) (
  input  logic       clk_i,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       mode_i,
  input  logic       step_i,
  input  logic       ped_req_A_i,
  input  logic       ped_req_B_i,
  output logic       l_red_A,
  output logic       l_yellow_A,
  output logic       l_green_A,
  output logic       l_red_B,
  output logic       l_yellow_B,
  output logic       l_green_B,
  output logic [6:0] cnt_A_o,
  output logic [6:0] cnt_B_o,
  output logic [2:0] phase_o,
  output logic       walk_A_o,
  output logic       walk_B_o
);

  // Countdown values must fit the two-digit display and every phase must last.
  if ((2 * T_ALLRED + T_GREEN + T_YELLOW > 99) || (T_GREEN < 1) || (T_YELLOW < 1) ||
      (T_ALLRED < 1) || (T_PED_CUT < 1)) begin : g_bad_durations
    $error("phase_scheduler: illegal phase durations");
  end

  localparam logic [6:0] TG  = 7'(T_GREEN);
  localparam logic [6:0] TY  = 7'(T_YELLOW);
  localparam logic [6:0] TAR = 7'(T_ALLRED);

  phase_e     phase_d, phase_q;
  logic       step_d, step_q;
  logic [6:0] timer;
  logic       t_load, t_dec;
  logic [6:0] t_load_val;
  logic       step_edge, is_green, ped_cut;
  logic       walk_a, walk_b;
  lamp_t      lamp_a, lamp_b;
  logic [6:0] cnt_a, cnt_b;

  function automatic logic [6:0] phase_dur(input phase_e p);
    case (p)
      A_GREEN, B_GREEN:   return TG;
      A_YELLOW, B_YELLOW: return TY;
      default:            return TAR;
    endcase
  endfunction

  assign step_edge = step_i & ~step_q;
  assign is_green  = (phase_q == A_GREEN) || (phase_q == B_GREEN);
  assign walk_a    = (phase_q == B_GREEN);
  assign walk_b    = (phase_q == A_GREEN);

`ifdef PED_REQ_EN
  localparam logic [6:0] TPC = 7'(T_PED_CUT);
  logic ped_a_d, ped_a_q, ped_b_d, ped_b_q;

  // Request latches: cleared on entering the green that serves them, requests ignored while already walking.
  always_comb begin
    ped_a_d = ped_a_q;
    ped_b_d = ped_b_q;
    if ((phase_d == B_GREEN) && (phase_q != B_GREEN)) begin
      ped_a_d = 1'b0;
    end else if (ped_req_A_i && !walk_a) begin
      ped_a_d = 1'b1;
    end
    if ((phase_d == A_GREEN) && (phase_q != A_GREEN)) begin
      ped_b_d = 1'b0;
    end else if (ped_req_B_i && !walk_b) begin
      ped_b_d = 1'b1;
    end
  end

  // Pedestrian request registers.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      ped_a_q <= 1'b0;
      ped_b_q <= 1'b0;
    end else begin
      ped_a_q <= ped_a_d;
      ped_b_q <= ped_b_d;
    end
  end

  assign ped_cut = !mode_i && (timer > TPC) &&
                   (((phase_q == A_GREEN) && ped_a_q) || ((phase_q == B_GREEN) && ped_b_q));
`else
  logic unused_ped;
  assign unused_ped = ped_req_A_i | ped_req_B_i;
  assign ped_cut    = 1'b0;
`endif

  // Next phase and timer control; a manual step beats any tick in the same cycle.
  always_comb begin
    phase_d    = phase_q;
    t_load     = 1'b0;
    t_load_val = timer;
    t_dec      = 1'b0;
    if (is_green && mode_i) begin
      if (step_edge) begin
        phase_d    = next_phase(phase_q);
        t_load     = 1'b1;
        t_load_val = TY;
      end
    end else if (ped_cut) begin
`ifdef PED_REQ_EN
      t_load     = 1'b1;
      t_load_val = TPC;
`endif
    end else if (tick_i) begin
      if (timer == 7'd1) begin
        phase_d    = next_phase(phase_q);
        t_load     = 1'b1;
        t_load_val = phase_dur(next_phase(phase_q));
      end else begin
        t_dec = 1'b1;
      end
    end
  end

  // Step input is level; keep its previous value for edge detection.
  always_comb begin
    step_d = step_i;
  end

  // Phase and step-history registers.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      phase_q <= A_GREEN;
      step_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      step_q  <= step_d;
    end
  end

  phase_timer #(
    .RST_VAL (T_GREEN)
  ) u_timer (
    .clk_i      (clk_i),
    .rst        (rst),
    .load_i     (t_load),
    .load_val_i (t_load_val),
    .dec_i      (t_dec),
    .cnt_o      (timer)
  );

  // Moore decode of lamps and per-direction countdowns; a red road counts to its next green.
  always_comb begin
    lamp_a = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
    lamp_b = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
    cnt_a  = timer;
    cnt_b  = timer;
    case (phase_q)
      A_GREEN: begin
        lamp_a = '{red: 1'b0, yellow: 1'b0, green: 1'b1};
        cnt_b  = timer + TY + TAR;
      end
      A_YELLOW: begin
        lamp_a = '{red: 1'b0, yellow: 1'b1, green: 1'b0};
        cnt_b  = timer + TAR;
      end
      ALLRED_1: begin
        cnt_a = timer + TG + TY + TAR;
      end
      B_GREEN: begin
        lamp_b = '{red: 1'b0, yellow: 1'b0, green: 1'b1};
        cnt_a  = timer + TY + TAR;
      end
      B_YELLOW: begin
        lamp_b = '{red: 1'b0, yellow: 1'b1, green: 1'b0};
        cnt_a  = timer + TAR;
      end
      default: begin
        cnt_b = timer + TG + TY + TAR;
      end
    endcase
  end

  assign l_red_A    = lamp_a.red;
  assign l_yellow_A = lamp_a.yellow;
  assign l_green_A  = lamp_a.green;
  assign l_red_B    = lamp_b.red;
  assign l_yellow_B = lamp_b.yellow;
  assign l_green_B  = lamp_b.green;
  assign cnt_A_o    = cnt_a;
  assign cnt_B_o    = cnt_b;
  assign phase_o    = phase_q;
  assign walk_A_o   = walk_a;
  assign walk_B_o   = walk_b;

endmodule

// File: tb/tb_phase_scheduler.sv
// Bench for phase_scheduler: vector table, directed corner sequences, random run vs reference model.
module tb_phase_scheduler;

  logic       clk_i = 1'b0;
  logic       rst = 1'b1, tick_i = 1'b0, mode_i = 1'b0, step_i = 1'b0;
  logic       ped_req_A_i = 1'b0, ped_req_B_i = 1'b0;
  logic       l_red_A, l_yellow_A, l_green_A, l_red_B, l_yellow_B, l_green_B;
  logic [6:0] cnt_A_o, cnt_B_o;
  logic [2:0] phase_o;
  logic       walk_A_o, walk_B_o;

  always #5 clk_i = ~clk_i;

  phase_scheduler dut (
    .clk_i       (clk_i),
    .rst         (rst),
    .tick_i      (tick_i),
    .mode_i      (mode_i),
    .step_i      (step_i),
    .ped_req_A_i (ped_req_A_i),
    .ped_req_B_i (ped_req_B_i),
    .l_red_A     (l_red_A),
    .l_yellow_A  (l_yellow_A),
    .l_green_A   (l_green_A),
    .l_red_B     (l_red_B),
    .l_yellow_B  (l_yellow_B),
    .l_green_B   (l_green_B),
    .cnt_A_o     (cnt_A_o),
    .cnt_B_o     (cnt_B_o),
    .phase_o     (phase_o),
    .walk_A_o    (walk_A_o),
    .walk_B_o    (walk_B_o)
  );

`ifdef PED_REQ_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: phase index 0..5 in ring order, seconds left in the phase.
  int dur[6] = '{25, 3, 2, 25, 3, 2};
  int m_phase = 0, m_timer = 25, m_step_prev = 0, m_pa = 0, m_pb = 0;

  typedef struct {
    bit    rst, tick, mode, step;
    int    reps;
    int    ph, ca, cb;
    string name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit t, bit m, bit s, int reps, int ph, int ca, int cb, string nm);
    vec_t v;
    v.rst = r; v.tick = t; v.mode = m; v.step = s; v.reps = reps;
    v.ph = ph; v.ca = ca; v.cb = cb; v.name = nm;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Seconds until the road whose green is phase g (yellow g+1) changes lamp.
  function automatic int cnt_for(int ph, int tm, int g);
    int s, k;
    if (ph == g || ph == g + 1) return tm;
    s = tm;
    k = (ph + 1) % 6;
    while (k != g) begin
      s += dur[k];
      k = (k + 1) % 6;
    end
    return s;
  endfunction

  // Advance the model by one clock from the current inputs, then let the DUT take the edge.
  task automatic clk_step();
    int  np, nt, npa, npb;
    bit  edge_s, green;
    np = m_phase; nt = m_timer; npa = m_pa; npb = m_pb;
    edge_s = step_i && (m_step_prev == 0);
    green  = (m_phase == 0) || (m_phase == 3);
    if (rst) begin
      np = 0; nt = dur[0]; npa = 0; npb = 0;
    end else begin
      if (mode_i && green) begin
        if (edge_s) begin
          np = m_phase + 1; nt = dur[np];
        end
      end else if (PED && !mode_i && green && m_timer > 5 &&
                   ((m_phase == 0 && m_pa != 0) || (m_phase == 3 && m_pb != 0))) begin
        nt = 5;
      end else if (tick_i) begin
        if (m_timer == 1) begin
          np = (m_phase + 1) % 6; nt = dur[np];
        end else begin
          nt = m_timer - 1;
        end
      end
      if (PED) begin
        if (np == 3 && m_phase != 3) npa = 0;
        else if (ped_req_A_i && m_phase != 3) npa = 1;
        if (np == 0 && m_phase != 0) npb = 0;
        else if (ped_req_B_i && m_phase != 0) npb = 1;
      end
    end
    @(posedge clk_i);
    #1;
    m_phase = np; m_timer = nt; m_pa = npa; m_pb = npb;
    m_step_prev = rst ? 0 : int'(step_i);
  endtask

  task automatic check_model();
    chk("phase", int'(phase_o), m_phase);
    chk("cnt_A", int'(cnt_A_o), cnt_for(m_phase, m_timer, 0));
    chk("cnt_B", int'(cnt_B_o), cnt_for(m_phase, m_timer, 3));
    chk("l_green_A", int'(l_green_A), int'(m_phase == 0));
    chk("l_yellow_A", int'(l_yellow_A), int'(m_phase == 1));
    chk("l_red_A", int'(l_red_A), int'(m_phase > 1));
    chk("l_green_B", int'(l_green_B), int'(m_phase == 3));
    chk("l_yellow_B", int'(l_yellow_B), int'(m_phase == 4));
    chk("l_red_B", int'(l_red_B), int'(m_phase < 3 || m_phase == 5));
    chk("walk_A", int'(walk_A_o), int'(m_phase == 3));
    chk("walk_B", int'(walk_B_o), int'(m_phase == 0));
  endtask

  task automatic goto_phase(input int target);
    int n;
    tick_i = 1'b1;
    n = 0;
    while (int'(phase_o) != target && n < 200) begin
      clk_step();
      n++;
    end
    tick_i = 1'b0;
    chk("goto_phase", int'(phase_o), target);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick_i = 1'b0; mode_i = 1'b0; step_i = 1'b0;
    ped_req_A_i = 1'b0; ped_req_B_i = 1'b0;
    clk_step();
    rst = 1'b0;
  endtask

  initial begin
    //          rst tick mode step reps ph cA  cB
    vecs.push_back(mk(1, 0, 0, 0, 1,  0, 25, 30, "reset"));
    vecs.push_back(mk(0, 1, 0, 0, 1,  0, 24, 29, "first_tick"));
    vecs.push_back(mk(0, 0, 0, 0, 3,  0, 24, 29, "no_tick"));
    vecs.push_back(mk(0, 1, 0, 0, 23, 0, 1,  6,  "green_last_sec"));
    vecs.push_back(mk(0, 1, 0, 0, 1,  1, 3,  5,  "a_yellow_entry"));
    vecs.push_back(mk(0, 1, 0, 0, 3,  2, 32, 2,  "allred1_entry"));
    vecs.push_back(mk(0, 1, 0, 0, 2,  3, 30, 25, "b_green_entry"));
    vecs.push_back(mk(0, 1, 1, 0, 10, 3, 30, 25, "manual_hold_b"));
    vecs.push_back(mk(0, 1, 1, 1, 1,  4, 5,  3,  "step_beats_tick"));
    vecs.push_back(mk(0, 1, 1, 1, 1,  4, 4,  2,  "yellow_ticks_manual"));
    vecs.push_back(mk(0, 1, 1, 0, 2,  5, 2,  32, "allred2_entry"));
    vecs.push_back(mk(0, 0, 1, 1, 1,  5, 2,  32, "step_in_allred"));
    vecs.push_back(mk(0, 1, 1, 0, 2,  0, 25, 30, "a_green_manual"));
    vecs.push_back(mk(0, 1, 1, 0, 8,  0, 25, 30, "manual_hold_a"));
    vecs.push_back(mk(0, 1, 0, 0, 8,  0, 17, 22, "auto_to_17"));
    vecs.push_back(mk(0, 1, 1, 0, 40, 0, 17, 22, "hold_17"));
    vecs.push_back(mk(0, 0, 1, 1, 1,  1, 3,  5,  "step_to_yellow"));
    vecs.push_back(mk(1, 0, 0, 0, 1,  0, 25, 30, "reset_mid_manual"));
    vecs.push_back(mk(0, 0, 0, 1, 1,  0, 25, 30, "step_in_auto"));
    vecs.push_back(mk(0, 0, 1, 1, 1,  0, 25, 30, "step_not_queued"));
    vecs.push_back(mk(0, 1, 1, 0, 1,  0, 25, 30, "hold_after"));
    vecs.push_back(mk(0, 1, 1, 1, 1,  1, 3,  5,  "step_tick_a"));
    vecs.push_back(mk(0, 1, 0, 0, 5,  3, 30, 25, "to_b_green"));
    vecs.push_back(mk(0, 1, 0, 0, 60, 3, 30, 25, "cycle_from_b"));
    vecs.push_back(mk(1, 0, 0, 0, 1,  0, 25, 30, "reset2"));
    vecs.push_back(mk(0, 1, 0, 0, 60, 0, 25, 30, "full_cycle"));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; tick_i = vecs[i].tick; mode_i = vecs[i].mode; step_i = vecs[i].step;
      repeat (vecs[i].reps) clk_step();
      chk({vecs[i].name, "_phase"}, int'(phase_o), vecs[i].ph);
      chk({vecs[i].name, "_cntA"}, int'(cnt_A_o), vecs[i].ca);
      chk({vecs[i].name, "_cntB"}, int'(cnt_B_o), vecs[i].cb);
      check_model();
    end

    // Reset during ALLRED_2 with a pending request must discard it.
    do_reset();
    goto_phase(5);
    ped_req_A_i = 1'b1;
    clk_step();
    ped_req_A_i = 1'b0;
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    chk("rst_allred2_phase", int'(phase_o), 0);
    chk("rst_allred2_cntA", int'(cnt_A_o), 25);
    tick_i = 1'b1;
    clk_step();
    tick_i = 1'b0;
    clk_step();
    chk("rst_clears_latch", int'(cnt_A_o), 24);
    check_model();

    // Pedestrian request at A_GREEN timer 20.
    do_reset();
    tick_i = 1'b1;
    repeat (5) clk_step();
    tick_i = 1'b0;
    chk("ped_pre_cntA", int'(cnt_A_o), 20);
    ped_req_A_i = 1'b1;
    clk_step();
    ped_req_A_i = 1'b0;
    clk_step();
    chk("ped_cut_cntA", int'(cnt_A_o), PED ? 5 : 20);
    check_model();
    tick_i = 1'b1;
    repeat (10) clk_step();
    tick_i = 1'b0;
    chk("ped_b_green_phase", int'(phase_o), PED ? 3 : 0);
    chk("ped_walk_A", int'(walk_A_o), PED ? 1 : 0);
    check_model();

    // Request for A while A already walks is ignored: next A_GREEN keeps full length.
    goto_phase(3);
    ped_req_A_i = 1'b1;
    clk_step();
    ped_req_A_i = 1'b0;
    goto_phase(0);
    clk_step();
    chk("ped_ignored_walking", int'(cnt_A_o), 25);
    check_model();

    // Randomised run against the reference model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom % 400) == 0;
      tick_i      = ($urandom % 3) == 0;
      if (($urandom % 60) == 0) mode_i = ~mode_i;
      if (($urandom % 8) == 0) step_i = ~step_i;
      ped_req_A_i = ($urandom % 40) == 0;
      ped_req_B_i = ($urandom % 40) == 0;
      clk_step();
      check_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
